mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning memory access cycles per transaction (legal range 1..15).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock (rising edge)
- rstn, in, 1, asynchronous active-low reset
- i_req, in, 1, instruction-refill request pulse
- i_addr, in, 32, instruction line address
- i_ack, out, 1, instruction completion pulse
- i_line, out, 4x32, instruction refill line
- d_req, in, 1, data request pulse
- d_we, in, 1, data write (1) or line read (0)
- d_funct3, in, 3, store width
- d_addr, in, 32, data address
- d_wdata, in, 32, store data
- d_ack, out, 1, data completion pulse
- d_line, out, 4x32, data read line
- mem_re, out, 1, memory read enable
- mem_we, out, 1, memory write enable
- mem_funct3, out, 3, memory width code
- mem_addr, out, 32, memory address
- mem_wdata, out, 32, memory write data
- mem_line, in, 4x32, combinational line from memory
- busy, out, 1, arbiter occupied

Function
REQ-003 Request capture: a req pulse sampled high SHALL set that port's pending bit and latch its addr, we, funct3 and wdata; a req while the same port is pending or in service SHALL be ignored.
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-005 In IDLE with exactly one port pending, that port SHALL be granted; the next state is ACCESS and the counter loads LATENCY-1.
REQ-006 In IDLE with both ports pending, the port not granted last SHALL win; last_grant resets to D, so I wins the first tie.
REQ-007 ACCESS SHALL last exactly LATENCY cycles, with the counter decrementing to 0, then go to DONE.
REQ-008 Throughout ACCESS, mem_addr, mem_funct3 and mem_wdata SHALL equal the granted port's latched values; mem_funct3 SHALL be 3'b010 for all reads.
REQ-009 For a read, mem_re SHALL be high for all ACCESS cycles, and mem_line SHALL be registered into the granted port's line output on the last ACCESS cycle.
REQ-010 For a write, mem_we SHALL be high only on the first ACCESS cycle, mem_re SHALL stay 0, and d_line SHALL be unchanged.
REQ-011 DONE SHALL last one cycle and pulse the granted port's ack. It SHALL clear that port's pending bit, update last_grant and return to IDLE; no grant occurs in DONE.
REQ-012 Outside ACCESS, mem_re, mem_we, mem_addr, mem_wdata and mem_funct3 SHALL be 0.
REQ-013 i_line and d_line SHALL hold their last captured value until the next read completes on that port.
REQ-014 busy SHALL be high when state≠IDLE or any pending bit is set.
REQ-015 An isolated request SHALL see its ack exactly LATENCY+2 cycles after the req pulse cycle; back-to-back service SHALL have a LATENCY+2 cycle spacing.
REQ-016 A req arriving during another port's service SHALL be captured and served after the next IDLE.
REQ-017 A req arriving in the same cycle as its own port's ack SHALL be ignored.

Reset
REQ-018 On rstn low, regardless of clock, the block SHALL force state=IDLE, all pending bits=0, counter=0 and last_grant=D. It SHALL also force i_ack=d_ack=0, i_line=d_line=0, all mem_* outputs=0 and busy=0.
REQ-019 Reset asserted mid-ACCESS SHALL abort the transaction with no ack and no further memory enable.

Verification (LATENCY=4; memory model returns {A+3,A+2,A+1,A} for mem_addr=A)
REQ-020 i_req pulse, cycle 0, i_addr=0x40 -> mem_re high cycles 2-5, and i_ack at cycle 6 with i_line={0x43,0x42,0x41,0x40}.
REQ-021 After reset, i_req and d_req (read, 0x80) in the same cycle 0 -> i_ack at cycle 6, then d_ack at cycle 12 with d_line={0x83,0x82,0x81,0x80}.
REQ-022 Three consecutive simultaneous request pairs -> grant order I, D, I, D, I, D.
REQ-023 d_req with d_we=1, d_addr=0x10, d_funct3=3'b000, d_wdata=0xAB -> mem_we high for one cycle with mem_addr=0x10 and mem_wdata=0xAB, then d_ack; d_line unchanged.
REQ-024 A second i_req pulse during I's ACCESS -> exactly one i_ack and one memory transaction.
REQ-025 rstn low at cycle 3 of an ACCESS -> all outputs 0 within that cycle, no ack; a fresh request after release completes per REQ-020.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction refill / data) in front of a single fixed-latency
// memory. Ties alternate between ports; each transaction runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_ack,
  output logic [3:0][31:0] i_line,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_funct3,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic [3:0][31:0] d_line,
  output logic             mem_re,
  output logic             mem_we,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [3:0][31:0] mem_line,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        i_pend_q, d_pend_q;
  logic        gnt_q, last_grant_q, rd_q;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic        d_we_q;
  logic [2:0]  d_funct3_q;
  logic        gnt_d, rd_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_d = PORT_I;
    if (i_pend_q && d_pend_q) gnt_d = ~last_grant_q;
    else if (d_pend_q)        gnt_d = PORT_D;
  end

  assign rd_d = (gnt_d == PORT_I) || !d_we_q;
  assign busy = (state_q != IDLE) || i_pend_q || d_pend_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      gnt_q        <= PORT_I;
      last_grant_q <= PORT_D;
      rd_q         <= 1'b0;
      i_addr_q     <= 32'd0;
      d_addr_q     <= 32'd0;
      d_wdata_q    <= 32'd0;
      d_we_q       <= 1'b0;
      d_funct3_q   <= 3'd0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_line       <= '0;
      d_line       <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_funct3   <= 3'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_we <= 1'b0;

      // A port's pending bit stays set through DONE, so repeats are dropped.
      if (i_req && !i_pend_q) begin
        i_pend_q <= 1'b1;
        i_addr_q <= i_addr;
      end
      if (d_req && !d_pend_q) begin
        d_pend_q   <= 1'b1;
        d_addr_q   <= d_addr;
        d_we_q     <= d_we;
        d_funct3_q <= d_funct3;
        d_wdata_q  <= d_wdata;
      end

      case (state_q)
        IDLE: begin
          if (i_pend_q || d_pend_q) begin
            state_q    <= ACCESS;
            cnt_q      <= 4'(LATENCY - 1);
            gnt_q      <= gnt_d;
            rd_q       <= rd_d;
            mem_re     <= rd_d;
            mem_we     <= !rd_d;
            mem_addr   <= (gnt_d == PORT_D) ? d_addr_q : i_addr_q;
            mem_funct3 <= rd_d ? 3'b010 : d_funct3_q;
            mem_wdata  <= (gnt_d == PORT_D) ? d_wdata_q : 32'd0;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q    <= DONE;
            mem_re     <= 1'b0;
            mem_funct3 <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if (rd_q) begin
              if (gnt_q == PORT_D) d_line <= mem_line;
              else                 i_line <= mem_line;
            end
            if (gnt_q == PORT_D) d_ack <= 1'b1;
            else                 i_ack <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          last_grant_q <= gnt_q;
          if (gnt_q == PORT_D) d_pend_q <= 1'b0;
          else                 i_pend_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory and ack
// events; two monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam logic PI = 1'b0;
  localparam logic PD = 1'b1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_req, d_req, d_we;
  logic [31:0]      i_addr, d_addr, d_wdata;
  logic [2:0]       d_funct3;
  logic             i_ack, d_ack, mem_re, mem_we, busy;
  logic [3:0][31:0] i_line, d_line, mem_line;
  logic [2:0]       mem_funct3;
  logic [31:0]      mem_addr, mem_wdata;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_line(i_line),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_line(d_line),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_line(mem_line),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory returns {A+3, A+2, A+1, A} for address A.
  assign mem_line = {mem_addr + 32'd3, mem_addr + 32'd2, mem_addr + 32'd1, mem_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wd;
  } mem_exp_t;

  typedef struct {
    logic             port;
    int               cyc;
    logic [3:0][31:0] il;
    logic [3:0][31:0] dl;
  } ack_exp_t;

  mem_exp_t mq[$];
  ack_exp_t aq[$];
  logic [3:0][31:0] m_i, m_d;
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [329:0] act, logic [329:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [329:0] outs();
    return {i_ack, d_ack, i_line, d_line, mem_re, mem_we, mem_funct3, mem_addr, mem_wdata, busy};
  endfunction

  function automatic logic [3:0][31:0] ln(logic [31:0] a);
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  // Push one transaction in expected completion order; start = first ACCESS cycle.
  task automatic expect_txn(logic port, int start, logic [31:0] addr, logic we,
                            logic [2:0] f3, logic [31:0] wd, logic [3:0][31:0] line);
    mem_exp_t me;
    ack_exp_t ae;
    me = '{start, addr, we, f3, wd};
    mq.push_back(me);
    if (!we) begin
      if (port) m_d = line;
      else      m_i = line;
    end
    ae = '{port, start + LAT, m_i, m_d};
    aq.push_back(ae);
  endtask

  task automatic drive(logic ir, logic [31:0] ia, logic dr, logic we, logic [2:0] f3,
                       logic [31:0] da, logic [31:0] wd);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_funct3 = f3; d_addr = da; d_wdata = wd;
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((mq.size() != 0 || aq.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d mem and %0d ack events outstanding, required 0", mq.size(), aq.size());
      mq.delete();
      aq.delete();
    end
    repeat (2) @(negedge clk);
    check("busy_idle", 330'(busy), 330'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_i = '0;
    m_d = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 330'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Memory-bus monitor: every cycle is either inside an expected access window or idle.
  mem_exp_t cur;
  int       acc_left = 0;
  bit       first_cyc;
  always @(negedge clk) begin
    if (!rstn) begin
      mq.delete();
      acc_left = 0;
    end else begin
      if (acc_left == 0 && (mem_re || mem_we)) begin
        if (mq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL mem_unexpected: re=%b we=%b addr=%h at cycle %0d, required no access", mem_re, mem_we, mem_addr, cyc);
        end else begin
          cur = mq.pop_front();
          acc_left = LAT;
          first_cyc = 1'b1;
          $display("mem %s addr=%h start cycle %0d", cur.we ? "write" : "read", mem_addr, cyc);
          check("mem_start_cycle", 330'(cyc), 330'(cur.cyc));
        end
      end
      if (acc_left > 0) begin
        check("mem_bus", 330'({mem_re, mem_we, mem_funct3, mem_addr, mem_wdata}),
              330'({!cur.we, cur.we && first_cyc, cur.f3, cur.addr, cur.wd}));
        acc_left--;
        first_cyc = 1'b0;
      end else begin
        check("mem_idle", 330'({mem_re, mem_we, mem_funct3, mem_addr, mem_wdata}), 330'(0));
      end
    end
  end

  // Ack monitor: each ack pops one expectation (port, cycle, both line outputs).
  ack_exp_t ae_m;
  always @(negedge clk) begin
    if (!rstn) begin
      aq.delete();
    end else if (i_ack || d_ack) begin
      if (aq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_unexpected: i_ack=%b d_ack=%b at cycle %0d, required none", i_ack, d_ack, cyc);
      end else begin
        ae_m = aq.pop_front();
        $display("ack port=%s cycle %0d i_line=%h d_line=%h", d_ack ? "D" : "I", cyc, i_line, d_line);
        check("ack", 330'({d_ack, i_ack, 32'(cyc), i_line, d_line}),
              330'({ae_m.port, !ae_m.port, 32'(ae_m.cyc), ae_m.il, ae_m.dl}));
      end
    end
  end

  int c;
  initial begin
    rstn = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_funct3 = '0; d_addr = '0; d_wdata = '0;
    m_i = '0; m_d = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 330'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Isolated instruction refill at 0x40.
    c = cyc;
    expect_txn(PI, c + 2, 32'h40, 1'b0, 3'b010, 32'h0, {32'h43, 32'h42, 32'h41, 32'h40});
    drive(1'b1, 32'h40, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("busy_pending", 330'(busy), 330'(1));
    drain();

    // Simultaneous pair right after reset: I first, D read 0x80 second.
    do_reset();
    c = cyc;
    expect_txn(PI, c + 2, 32'h200, 1'b0, 3'b010, 32'h0, {32'h203, 32'h202, 32'h201, 32'h200});
    expect_txn(PD, c + 8, 32'h80, 1'b0, 3'b010, 32'h5555_0000, {32'h83, 32'h82, 32'h81, 32'h80});
    drive(1'b1, 32'h200, 1'b1, 1'b0, 3'b111, 32'h80, 32'h5555_0000);
    drain();

    // Three more simultaneous pairs keep alternating I, D.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c = cyc;
      expect_txn(PI, c + 2, 32'h1000 + 32'(k) * 32'h100, 1'b0, 3'b010, 32'h0, ln(32'h1000 + 32'(k) * 32'h100));
      expect_txn(PD, c + 8, 32'h2000 + 32'(k) * 32'h100, 1'b0, 3'b010, 32'h0, ln(32'h2000 + 32'(k) * 32'h100));
      drive(1'b1, 32'h1000 + 32'(k) * 32'h100, 1'b1, 1'b0, 3'b010, 32'h2000 + 32'(k) * 32'h100, 32'h0);
      drain();
    end

    // After a lone I service, a tie goes to D.
    @(negedge clk);
    c = cyc;
    expect_txn(PI, c + 2, 32'h600, 1'b0, 3'b010, 32'h0, {32'h603, 32'h602, 32'h601, 32'h600});
    drive(1'b1, 32'h600, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drain();
    c = cyc;
    expect_txn(PD, c + 2, 32'h780, 1'b0, 3'b010, 32'h0, {32'h783, 32'h782, 32'h781, 32'h780});
    expect_txn(PI, c + 8, 32'h700, 1'b0, 3'b010, 32'h0, {32'h703, 32'h702, 32'h701, 32'h700});
    drive(1'b1, 32'h700, 1'b1, 1'b0, 3'b010, 32'h780, 32'h0);
    drain();

    // Byte store: one mem_we cycle, d_line keeps the 0x780 line.
    c = cyc;
    expect_txn(PD, c + 2, 32'h10, 1'b1, 3'b000, 32'hAB, '0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h10, 32'hAB);
    drain();

    // Repeat I pulses during ACCESS and on the ack cycle are ignored.
    c = cyc;
    expect_txn(PI, c + 2, 32'h300, 1'b0, 3'b010, 32'h0, {32'h303, 32'h302, 32'h301, 32'h300});
    drive(1'b1, 32'h300, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drain();
    repeat (8) @(negedge clk);

    // D request arriving during I service is queued and served next.
    c = cyc;
    expect_txn(PI, c + 2, 32'h900, 1'b0, 3'b010, 32'h0, {32'h903, 32'h902, 32'h901, 32'h900});
    expect_txn(PD, c + 8, 32'hA00, 1'b0, 3'b010, 32'h0, {32'hA03, 32'hA02, 32'hA01, 32'hA00});
    drive(1'b1, 32'h900, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'hA00, 32'h0);
    drain();

    // Reset in the third ACCESS cycle aborts the transaction.
    c = cyc;
    expect_txn(PI, c + 2, 32'hB00, 1'b0, 3'b010, 32'h0, ln(32'hB00));
    drive(1'b1, 32'hB00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("reset_mid_access", outs(), 330'(0));
    m_i = '0;
    m_d = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    c = cyc;
    expect_txn(PI, c + 2, 32'h40, 1'b0, 3'b010, 32'h0, {32'h43, 32'h42, 32'h41, 32'h40});
    drive(1'b1, 32'h40, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
